// File: rtl/tour_replay_ctrl.sv
// tour_replay_ctrl
// Sequences a knight's-tour run. It launches the solver, waits for the solution,
// and then replays each solved one-hot move as two motion commands: a vertical
// leg followed by a horizontal leg. The block owns the single command port into
// the motion processor. Host commands are passed through only while no replay
// is active.

module tour_replay_ctrl #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        tour_go,
    input  logic        tour_done,
    output logic [4:0]  mv_indx,
    input  logic [7:0]  move,
    input  logic [15:0] ext_cmd,
    input  logic        ext_cmd_vld,
    output logic        ext_cmd_ack,
    output logic [15:0] cmd,
    output logic        cmd_vld,
    input  logic        cmd_ack,
    input  logic        mv_cmplt,
    output logic        busy,
    output logic        tour_cmplt,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        SOLVE  = 3'd2,
        VERT   = 3'd3,
        WAIT_V = 3'd4,
        HORZ   = 3'd5,
        WAIT_H = 3'd6,
        NEXT   = 3'd7
    } state_t;

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    localparam logic [3:0] OP_VERT = 4'h4;
    localparam logic [3:0] OP_HORZ = 4'h5;

    localparam logic [7:0] HDG_NORTH = 8'h00;
    localparam logic [7:0] HDG_WEST  = 8'h3F;
    localparam logic [7:0] HDG_SOUTH = 8'h7F;
    localparam logic [7:0] HDG_EAST  = 8'hBF;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  indx_nxt;
    logic        busy_nxt;
    logic        go_nxt;
    logic        cmplt_nxt;
    logic        err_nxt;

    logic        move_ok;
    logic        vert_south;
    logic [3:0]  vert_sq;
    logic        horz_west;
    logic [3:0]  horz_sq;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic [15:0] int_cmd;
    logic        int_vld;

    // Decode the one-hot move into leg directions and leg lengths. Any value that is not exactly one-hot is flagged as invalid.
    always_comb begin
        move_ok    = 1'b1;
        vert_south = 1'b0;
        vert_sq    = 4'd0;
        horz_west  = 1'b0;
        horz_sq    = 4'd0;
        case (move)
            8'h01: begin vert_south = 1'b0; vert_sq = 4'd2; horz_west = 1'b0; horz_sq = 4'd1; end
            8'h02: begin vert_south = 1'b0; vert_sq = 4'd2; horz_west = 1'b1; horz_sq = 4'd1; end
            8'h04: begin vert_south = 1'b0; vert_sq = 4'd1; horz_west = 1'b1; horz_sq = 4'd2; end
            8'h08: begin vert_south = 1'b1; vert_sq = 4'd1; horz_west = 1'b1; horz_sq = 4'd2; end
            8'h10: begin vert_south = 1'b1; vert_sq = 4'd2; horz_west = 1'b1; horz_sq = 4'd1; end
            8'h20: begin vert_south = 1'b1; vert_sq = 4'd2; horz_west = 1'b0; horz_sq = 4'd1; end
            8'h40: begin vert_south = 1'b1; vert_sq = 4'd1; horz_west = 1'b0; horz_sq = 4'd2; end
            8'h80: begin vert_south = 1'b0; vert_sq = 4'd1; horz_west = 1'b0; horz_sq = 4'd2; end
            default: move_ok = 1'b0;
        endcase
    end

    // Assemble both leg commands in the {opcode, heading, squares} format.
    always_comb begin
        vert_cmd = {OP_VERT, (vert_south ? HDG_SOUTH : HDG_NORTH), vert_sq};
        horz_cmd = {OP_HORZ, (horz_west ? HDG_WEST : HDG_EAST), horz_sq};
    end

    // Drive the replay's own command. Legs are decoded live from the addressed move, so the command is valid in the first VERT cycle.
    always_comb begin
        int_cmd = 16'h0000;
        int_vld = 1'b0;
        case (state)
            VERT: begin
                int_cmd = move_ok ? vert_cmd : 16'h0000;
                int_vld = move_ok;
            end
            HORZ: begin
                int_cmd = horz_cmd;
                int_vld = 1'b1;
            end
            default: begin
                int_cmd = 16'h0000;
                int_vld = 1'b0;
            end
        endcase
    end

    // Arbitrate the motion command port. The host owns the port only while no replay is active.
    always_comb begin
        cmd         = busy ? int_cmd : ext_cmd;
        cmd_vld     = busy ? int_vld : ext_cmd_vld;
        ext_cmd_ack = busy ? 1'b0    : cmd_ack;
    end

    // Compute the next state and the next values of the registered outputs.
    always_comb begin
        state_nxt = state;
        indx_nxt  = mv_indx;
        busy_nxt  = busy;
        go_nxt    = 1'b0;
        cmplt_nxt = 1'b0;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LAUNCH;
                    indx_nxt  = 5'd0;
                    busy_nxt  = 1'b1;
                    go_nxt    = 1'b1;
                    err_nxt   = 1'b0;
                end
            end
            LAUNCH: begin
                state_nxt = SOLVE;
            end
            SOLVE: begin
                if (tour_done) begin
                    state_nxt = VERT;
                end
            end
            VERT: begin
                if (!move_ok) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    err_nxt   = 1'b1;
                end else if (cmd_ack) begin
                    state_nxt = WAIT_V;
                end
            end
            WAIT_V: begin
                if (mv_cmplt) begin
                    state_nxt = HORZ;
                end
            end
            HORZ: begin
                if (cmd_ack) begin
                    state_nxt = WAIT_H;
                end
            end
            WAIT_H: begin
                if (mv_cmplt) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (mv_indx == LAST_INDX) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    cmplt_nxt = 1'b1;
                end else begin
                    state_nxt = VERT;
                    indx_nxt  = mv_indx + 5'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Hold the state and the registered outputs. Asserting reset aborts any replay immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mv_indx    <= 5'd0;
            busy       <= 1'b0;
            tour_go    <= 1'b0;
            tour_cmplt <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            mv_indx    <= indx_nxt;
            busy       <= busy_nxt;
            tour_go    <= go_nxt;
            tour_cmplt <= cmplt_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tour_replay_ctrl.sv
// tb_tour_replay_ctrl
// Directed bench for tour_replay_ctrl. The instance "dut" uses the default 24-move
// tour. The instance "dut1" uses a single-move tour. Both instances read moves from
// the same table.

module tb_tour_replay_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, start1, tour_done, cmd_ack, mv_cmplt, ext_cmd_vld;
    logic [15:0] ext_cmd;

    logic        tour_go, busy, tour_cmplt, err, ext_cmd_ack, cmd_vld;
    logic [4:0]  mv_indx;
    logic [15:0] cmd;
    logic [7:0]  move;

    logic        tour_go1, busy1, tour_cmplt1, err1, ext_cmd_ack1, cmd_vld1;
    logic [4:0]  mv_indx1;
    logic [15:0] cmd1;
    logic [7:0]  move1;

    logic [7:0]  move_tab [0:31];
    int          mv_bit   [0:31];
    logic [15:0] exp_v    [0:7];
    logic [15:0] exp_h    [0:7];

    int errors = 0;
    int checks = 0;
    int cmplt_cnt = 0;
    int legs_seen = 0;

    tour_replay_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .tour_go(tour_go), .tour_done(tour_done),
        .mv_indx(mv_indx), .move(move), .ext_cmd(ext_cmd), .ext_cmd_vld(ext_cmd_vld),
        .ext_cmd_ack(ext_cmd_ack), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_ack(cmd_ack),
        .mv_cmplt(mv_cmplt), .busy(busy), .tour_cmplt(tour_cmplt), .err(err)
    );

    tour_replay_ctrl #(.NUM_MOVES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .tour_go(tour_go1), .tour_done(tour_done),
        .mv_indx(mv_indx1), .move(move1), .ext_cmd(ext_cmd), .ext_cmd_vld(ext_cmd_vld),
        .ext_cmd_ack(ext_cmd_ack1), .cmd(cmd1), .cmd_vld(cmd_vld1), .cmd_ack(cmd_ack),
        .mv_cmplt(mv_cmplt), .busy(busy1), .tour_cmplt(tour_cmplt1), .err(err1)
    );

    assign move  = move_tab[mv_indx];
    assign move1 = move_tab[mv_indx1];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tour_cmplt) cmplt_cnt++;
    end

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++; if (tour_go !== 1'b0) begin errors++; $display("[TB] FAIL reset_tour_go got=%b want=0", tour_go); end
        checks++; if (tour_cmplt !== 1'b0) begin errors++; $display("[TB] FAIL reset_tour_cmplt got=%b want=0", tour_cmplt); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b want=0", err); end
        checks++; if (mv_indx !== 5'd0) begin errors++; $display("[TB] FAIL reset_mv_indx got=%0d want=0", mv_indx); end
        checks++; if (cmd_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_vld got=%b want=0", cmd_vld); end
        checks++; if (cmd !== 16'h0000) begin errors++; $display("[TB] FAIL reset_cmd got=%h want=0000", cmd); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_single_move();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b want=1", busy1); end
        checks++; if (tour_go1 !== 1'b1) begin errors++; $display("[TB] FAIL single_tour_go got=%b want=1", tour_go1); end
        @(negedge clk);
        checks++; if (tour_go1 !== 1'b0) begin errors++; $display("[TB] FAIL single_tour_go_pulse got=%b want=0", tour_go1); end
        tour_done = 1'b1;
        @(negedge clk);
        tour_done = 1'b0;
        checks++; if (cmd_vld1 !== 1'b1) begin errors++; $display("[TB] FAIL single_vert_vld got=%b want=1", cmd_vld1); end
        checks++; if (cmd1 !== 16'h4002) begin errors++; $display("[TB] FAIL single_vert_cmd got=%h want=4002", cmd1); end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        checks++; if (cmd_vld1 !== 1'b0) begin errors++; $display("[TB] FAIL single_vld_drop got=%b want=0", cmd_vld1); end
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        checks++; if (cmd1 !== 16'h5BF1 || cmd_vld1 !== 1'b1) begin errors++; $display("[TB] FAIL single_horz_cmd got=%h/%b want=5bf1/1", cmd1, cmd_vld1); end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        checks++; if (tour_cmplt1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("[TB] FAIL single_next got cmplt=%b busy=%b want 0/1", tour_cmplt1, busy1); end
        @(negedge clk);
        checks++; if (tour_cmplt1 !== 1'b1) begin errors++; $display("[TB] FAIL single_tour_cmplt got=%b want=1", tour_cmplt1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end got=%b want=0", busy1); end
        @(negedge clk);
        checks++; if (tour_cmplt1 !== 1'b0) begin errors++; $display("[TB] FAIL single_cmplt_pulse got=%b want=0", tour_cmplt1); end
    endtask

    task automatic test_ack_cmplt_same_cycle();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        tour_done = 1'b1;
        @(negedge clk);
        tour_done = 1'b0;
        cmd_ack = 1'b1;
        mv_cmplt = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        mv_cmplt = 1'b0;
        @(negedge clk);
        checks++; if (cmd_vld1 !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_cmplt_ignored got vld=%b want=0", cmd_vld1); end
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        checks++; if (cmd_vld1 !== 1'b1 || cmd1 !== 16'h5BF1) begin errors++; $display("[TB] FAIL same_cycle_horz got=%h/%b want=5bf1/1", cmd1, cmd_vld1); end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_end_busy got=%b want=0", busy1); end
    endtask

    task automatic test_arbitration();
        ext_cmd = 16'h1234;
        ext_cmd_vld = 1'b1;
        #1;
        checks++; if (cmd !== 16'h1234 || cmd_vld !== 1'b1) begin errors++; $display("[TB] FAIL arb_idle_fwd got=%h/%b want=1234/1", cmd, cmd_vld); end
        checks++; if (ext_cmd_ack !== 1'b0) begin errors++; $display("[TB] FAIL arb_idle_ack_low got=%b want=0", ext_cmd_ack); end
        cmd_ack = 1'b1;
        #1;
        checks++; if (ext_cmd_ack !== 1'b1) begin errors++; $display("[TB] FAIL arb_idle_ack_high got=%b want=1", ext_cmd_ack); end
        @(negedge clk);
        cmd_ack = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cmd_ack = 1'b1;
        #1;
        checks++; if (ext_cmd_ack !== 1'b0) begin errors++; $display("[TB] FAIL arb_busy_ack got=%b want=0", ext_cmd_ack); end
        checks++; if (cmd !== 16'h0000 || cmd_vld !== 1'b0) begin errors++; $display("[TB] FAIL arb_busy_fwd got=%h/%b want=0000/0", cmd, cmd_vld); end
        cmd_ack = 1'b0;
        @(negedge clk);
        tour_done = 1'b1;
        @(negedge clk);
        tour_done = 1'b0;
        checks++; if (cmd !== 16'h4002 || cmd_vld !== 1'b1) begin errors++; $display("[TB] FAIL arb_busy_vert got=%h/%b want=4002/1", cmd, cmd_vld); end
        cmd_ack = 1'b1;
        #1;
        checks++; if (ext_cmd_ack !== 1'b0) begin errors++; $display("[TB] FAIL arb_busy_vert_ack got=%b want=0", ext_cmd_ack); end
        @(negedge clk);
        cmd_ack = 1'b0;
        ext_cmd_vld = 1'b0;
        ext_cmd = 16'h0000;
        pulse_reset();
    endtask

    task automatic start_and_solve();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || tour_go !== 1'b1) begin errors++; $display("[TB] FAIL launch got busy=%b go=%b want 1/1", busy, tour_go); end
        checks++; if (err !== 1'b0 || mv_indx !== 5'd0) begin errors++; $display("[TB] FAIL launch_clear got err=%b indx=%0d want 0/0", err, mv_indx); end
        @(negedge clk);
        tour_done = 1'b1;
        @(negedge clk);
        tour_done = 1'b0;
    endtask

    task automatic do_legs(input int first_leg, input int n_legs, input int ack_dly, input int cmp_dly);
        int          wait_cnt;
        int          idx;
        logic [15:0] exp_cmd;
        for (int leg = first_leg; leg < first_leg + n_legs; leg++) begin
            wait_cnt = 0;
            idx = leg / 2;
            while (cmd_vld !== 1'b1 && wait_cnt < 200) begin
                @(negedge clk);
                wait_cnt++;
            end
            checks++;
            if (cmd_vld !== 1'b1) begin
                errors++;
                $display("[TB] FAIL leg_timeout leg=%0d got vld=%b want=1", leg, cmd_vld);
                return;
            end
            legs_seen++;
            exp_cmd = (leg % 2 == 0) ? exp_v[mv_bit[idx]] : exp_h[mv_bit[idx]];
            checks++; if (cmd !== exp_cmd) begin errors++; $display("[TB] FAIL leg_cmd leg=%0d got=%h want=%h", leg, cmd, exp_cmd); end
            checks++; if (mv_indx !== 5'(idx)) begin errors++; $display("[TB] FAIL leg_indx leg=%0d got=%0d want=%0d", leg, mv_indx, idx); end
            repeat (ack_dly) @(negedge clk);
            checks++; if (cmd_vld !== 1'b1 || cmd !== exp_cmd) begin errors++; $display("[TB] FAIL leg_hold leg=%0d got=%h/%b want=%h/1", leg, cmd, cmd_vld, exp_cmd); end
            cmd_ack = 1'b1;
            @(negedge clk);
            cmd_ack = 1'b0;
            checks++; if (cmd_vld !== 1'b0) begin errors++; $display("[TB] FAIL leg_vld_drop leg=%0d got=%b want=0", leg, cmd_vld); end
            repeat (cmp_dly) @(negedge clk);
            mv_cmplt = 1'b1;
            @(negedge clk);
            mv_cmplt = 1'b0;
        end
    endtask

    task automatic test_full_replay();
        int c0;
        int l0;
        c0 = cmplt_cnt;
        l0 = legs_seen;
        start_and_solve();
        do_legs(0, 48, 3, 10);
        repeat (3) @(negedge clk);
        checks++; if (legs_seen - l0 !== 48) begin errors++; $display("[TB] FAIL full_leg_count got=%0d want=48", legs_seen - l0); end
        checks++; if (cmplt_cnt - c0 !== 1) begin errors++; $display("[TB] FAIL full_tour_cmplt_count got=%0d want=1", cmplt_cnt - c0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_bad_move();
        int vld_seen;
        move_tab[5] = 8'h00;
        start_and_solve();
        do_legs(0, 10, 0, 0);
        vld_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_vld === 1'b1) vld_seen++;
        end
        checks++; if (vld_seen !== 0) begin errors++; $display("[TB] FAIL bad_no_cmd got=%0d cycles valid want=0", vld_seen); end
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL bad_err got=%b want=1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL bad_busy got=%b want=0", busy); end
        move_tab[5] = 8'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL bad_restart got err=%b busy=%b want 0/1", err, busy); end
        pulse_reset();
    endtask

    task automatic test_reset_mid_replay();
        int c0;
        c0 = cmplt_cnt;
        start_and_solve();
        do_legs(0, 3, 0, 0);
        checks++; if (cmd_vld !== 1'b1 || mv_indx !== 5'd1) begin errors++; $display("[TB] FAIL midrst_horz got vld=%b indx=%0d want 1/1", cmd_vld, mv_indx); end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        checks++; if (mv_indx !== 5'd0) begin errors++; $display("[TB] FAIL midrst_indx got=%0d want=0", mv_indx); end
        checks++; if (cmd_vld !== 1'b0 || cmd !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_cmd got=%h/%b want=0000/0", cmd, cmd_vld); end
        checks++; if (tour_cmplt !== 1'b0 || tour_go !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flags got cmplt=%b go=%b err=%b want 0", tour_cmplt, tour_go, err); end
        @(negedge clk);
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cmplt_cnt !== c0) begin errors++; $display("[TB] FAIL midrst_stray_cmplt got=%0d want=0", cmplt_cnt - c0); end
        start_and_solve();
        do_legs(0, 1, 0, 0);
        pulse_reset();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; tour_done = 1'b0;
        cmd_ack = 1'b0; mv_cmplt = 1'b0; ext_cmd = 16'h0000; ext_cmd_vld = 1'b0;
        for (int i = 0; i < 32; i++) begin
            move_tab[i] = 8'h01 << (i % 8);
            mv_bit[i]   = i % 8;
        end
        exp_v[0] = 16'h4002; exp_h[0] = 16'h5BF1;
        exp_v[1] = 16'h4002; exp_h[1] = 16'h53F1;
        exp_v[2] = 16'h4001; exp_h[2] = 16'h53F2;
        exp_v[3] = 16'h47F1; exp_h[3] = 16'h53F2;
        exp_v[4] = 16'h47F2; exp_h[4] = 16'h53F1;
        exp_v[5] = 16'h47F2; exp_h[5] = 16'h5BF1;
        exp_v[6] = 16'h47F1; exp_h[6] = 16'h5BF2;
        exp_v[7] = 16'h4001; exp_h[7] = 16'h5BF2;
        test_reset();
        test_single_move();
        test_ack_cmplt_same_cycle();
        test_arbitration();
        test_full_replay();
        test_bad_move();
        test_reset_mid_replay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the bench completed");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/tour_replay_ctrl.md
# tour_replay_ctrl

Sequences a complete knight's-tour run. On `start` it launches the tour solver, waits for the solution, then reads the 24 solved moves out by index. Each one-hot move becomes two motion commands: a vertical leg, then a horizontal leg. Commands are issued to the downstream motion/command processor, and the block waits for each leg to finish. It also owns the single command port into the motion processor, passing external (host) commands through only when no replay is active.

## Interface
Parameters:
- `NUM_MOVES`, default 24: number of solved moves to replay; `mv_indx` runs 0..NUM_MOVES-1.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a full solve-and-replay; sampled in IDLE only.
- `tour_go`  out  1  one-cycle pulse that launches the solver.
- `tour_done`  in  1  solver-complete pulse.
- `mv_indx`  out  5  registered index of the move being replayed.
- `move`  in  8  one-hot move addressed by `mv_indx`, valid combinationally in the same cycle.
- `ext_cmd`  in  16  host command.
- `ext_cmd_vld`  in  1  host command valid.
- `ext_cmd_ack`  out  1  host command accepted.
- `cmd`  out  16  command to the motion processor.
- `cmd_vld`  out  1  command valid.
- `cmd_ack`  in  1  motion processor accepts `cmd` in this cycle.
- `mv_cmplt`  in  1  pulse: the last accepted leg has finished.
- `busy`  out  1  high from `start` acceptance until the replay ends.
- `tour_cmplt`  out  1  one-cycle pulse after the last leg of the last move completes.
- `err`  out  1  sticky flag: a non-one-hot move was read. Cleared on the next accepted `start`.

## Operation
- States: IDLE, LAUNCH, SOLVE, VERT, WAIT_V, HORZ, WAIT_H, NEXT.
- IDLE + `start`: go to LAUNCH, clear `err` and `mv_indx`, set `busy`. In any other state, `start` is ignored.
- LAUNCH: `tour_go`=1 for exactly this cycle, then go to SOLVE.
- SOLVE: wait for `tour_done`, then go to VERT.
- Decode `move` to signed offsets (dx,dy):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- Direction convention: +y is north, +x is east.
- Command format: {opcode[3:0], heading[7:0], squares[3:0]}.
  - Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
  - Vertical leg: opcode 4'h4, squares = |dy|.
  - Horizontal leg: opcode 4'h5 (move with fanfare), squares = |dx|.
- VERT: drive the vertical command with `cmd_vld`=1 and hold it until `cmd_ack`. On `cmd_ack`, go to WAIT_V.
- WAIT_V: wait for `mv_cmplt`, then go to HORZ.
- HORZ and WAIT_H: same as VERT and WAIT_V, using the horizontal command.
- NEXT:
  - If `mv_indx`==NUM_MOVES-1: pulse `tour_cmplt`, clear `busy`, go to IDLE.
  - Otherwise: increment `mv_indx`, go to VERT.
- Invalid move: if `move` is not one-hot on entry to VERT (including 8'h00), set `err`, clear `busy`, go to IDLE, and issue no command.
- Port arbitration:
  - When `busy`=0: `cmd`=`ext_cmd`, `cmd_vld`=`ext_cmd_vld`, `ext_cmd_ack`=`cmd_ack`.
  - When `busy`=1: `ext_cmd_ack`=0 and the host command is not forwarded.
  - Ownership switches only at IDLE boundaries, never in the middle of a handshake.

## Timing
- Reset values: state IDLE; `tour_go`, `busy`, `tour_cmplt`, `err`, internal `cmd_vld` all 0; `mv_indx` 0; internal `cmd` 16'h0000.
- `start` sampled in cycle N: `busy`=1 and `tour_go`=1 in N+1; state SOLVE from N+2.
- `tour_done` sampled in cycle M: `cmd_vld`=1 with the vertical command from M+1.
- `cmd_ack` and `cmd_vld` high together: the command is consumed. `cmd_vld` drops the next cycle.
- `mv_cmplt` is honoured only in WAIT_V and WAIT_H; in any other state it is ignored.
- `mv_cmplt` in the same cycle as `cmd_ack` (in VERT or HORZ) does not count toward that leg.
- Advance: `mv_cmplt` in WAIT_H goes to NEXT the following cycle, then VERT with the new `mv_indx` one cycle later.
- End of tour: `tour_cmplt` is high in the cycle after NEXT detects the last index; `busy` falls in the same cycle.
- Asynchronous `rst` mid-replay: immediate return to IDLE and all reset values; `busy` drops at once.
- `tour_done` outside SOLVE is ignored.
- `mv_indx` is 5-bit; it must never reach NUM_MOVES, so there is no wrap-around.

## Test plan
- Single move: NUM_MOVES=1, `move`=8'h01, immediate acks and completes. Required: `cmd`=16'h4002, then 16'h5BF1; then `tour_cmplt` pulse; `busy` returns to 0.
- Negative offsets: `move`=8'h08. Required: 16'h47F1 (south 1), then 16'h53F2 (west 2).
- Full 24-move replay with `cmd_ack` delayed 3 cycles and `mv_cmplt` delayed 10 cycles. Required: 48 commands, in `mv_indx` order 0..23; exactly one `tour_cmplt`.
- Arbitration: `ext_cmd`=16'h1234 with `ext_cmd_vld` while idle, then again while busy.
  - Idle: forwarded, and `ext_cmd_ack` follows `cmd_ack`.
  - Busy: `ext_cmd_ack`=0 and never forwarded.
- Bad move: `move`=8'h00 at `mv_indx` 5. Required: `err`=1, no command issued, IDLE. A following `start` clears `err`.
- Reset mid-WAIT_H: assert `rst`. Required: all outputs take their reset values in the same cycle; no stray `tour_cmplt`. A `start` after reset release replays from `mv_indx` 0.
